// File: rtl/ext_bus_initiator.sv
// ext_bus_initiator: single-outstanding master for the 16-bit external-bus bridge port.
// Latches one read/write request, drives the bridge strobes until acknowledge or
// watchdog expiry, then returns a one-cycle response pulse.
module ext_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic [7:0]  timeout_count,
    output logic [4:0]  bus_address,
    output logic [1:0]  bus_byte_enable,
    output logic        bus_read,
    output logic        bus_write,
    output logic [15:0] bus_write_data,
    input  logic        bus_acknowledge,
    input  logic [15:0] bus_read_data
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned BE_W   = 2;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TOC_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic                r_write,      w_write_nxt;
    logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr,       w_addr_nxt;
    logic [BE_W-1:0]     r_be,         w_be_nxt;
    logic [DATA_W-1:0]   r_wdata,      w_wdata_nxt;
    logic                r_bus_read,   w_bus_read_nxt;
    logic                r_bus_write,  w_bus_write_nxt;
    logic                r_rsp_valid,  w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata,  w_rsp_rdata_nxt;
    logic                r_rsp_error,  w_rsp_error_nxt;
    logic [TOC_W-1:0]    r_to_cnt,     w_to_cnt_nxt;
    logic                w_accept;
    logic                w_expired;

    // Handshake and state decodes; ready is forced low while reset is held.
    assign req_ready = (r_state == S_IDLE) & ~reset_reset;
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_write_nxt     = r_write;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = r_addr;
        w_be_nxt        = r_be;
        w_wdata_nxt     = r_wdata;
        w_bus_read_nxt  = 1'b0;
        w_bus_write_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_error_nxt = r_rsp_error;
        w_to_cnt_nxt    = r_to_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_write_nxt     = req_write;
                    w_addr_nxt      = req_addr;
                    w_be_nxt        = req_be;
                    w_wdata_nxt     = req_wdata;
                    w_cnt_nxt       = '0;
                    w_bus_read_nxt  = ~req_write;
                    w_bus_write_nxt = req_write;
                    w_state_nxt     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Acknowledge takes priority over a watchdog expiry in the same cycle.
                if (bus_acknowledge) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_write ? '0 : bus_read_data;
                    w_rsp_error_nxt = 1'b0;
                    w_state_nxt     = S_DONE;
                end else if (w_expired) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_error_nxt = 1'b1;
                    if (r_to_cnt != {TOC_W{1'b1}}) begin
                        w_to_cnt_nxt = r_to_cnt + TOC_W'(1);
                    end
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt       = r_cnt + CNT_W'(1);
                    w_bus_read_nxt  = r_bus_read;
                    w_bus_write_nxt = r_bus_write;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops the strobes immediately.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_write     <= w_write_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_be        <= w_be_nxt;
            r_wdata     <= w_wdata_nxt;
            r_bus_read  <= w_bus_read_nxt;
            r_bus_write <= w_bus_write_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
        end
    end

    assign bus_address     = r_addr;
    assign bus_byte_enable = r_be;
    assign bus_write_data  = r_wdata;
    assign bus_read        = r_bus_read;
    assign bus_write       = r_bus_write;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_error       = r_rsp_error;
    assign timeout_count   = r_to_cnt;

endmodule

// File: tb/tb_ext_bus_initiator.sv
// tb_ext_bus_initiator: directed and randomized checks of ext_bus_initiator against a
// transaction-level model (strobe length, response timing, data, timeout counter).
module tb_ext_bus_initiator;
    localparam int unsigned T = 8;

    logic        clk_clk         = 1'b0;
    logic        reset_reset     = 1'b1;
    logic        req_valid       = 1'b0;
    logic        req_ready;
    logic        req_write       = 1'b0;
    logic [4:0]  req_addr        = '0;
    logic [1:0]  req_be          = '0;
    logic [15:0] req_wdata       = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic [7:0]  timeout_count;
    logic [4:0]  bus_address;
    logic [1:0]  bus_byte_enable;
    logic        bus_read;
    logic        bus_write;
    logic [15:0] bus_write_data;
    logic        bus_acknowledge = 1'b0;
    logic [15:0] bus_read_data   = '0;

    int n_cmp  = 0;
    int n_err  = 0;
    int exp_to = 0;
    logic [15:0] rdq [0:9];

    always #5 clk_clk = ~clk_clk;

    ext_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_be          (req_be),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .busy            (busy),
        .timeout_count   (timeout_count),
        .bus_address     (bus_address),
        .bus_byte_enable (bus_byte_enable),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_write_data  (bus_write_data),
        .bus_acknowledge (bus_acknowledge),
        .bus_read_data   (bus_read_data)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction from IDLE; ack_at in 1..T acknowledges in that ACCESS cycle,
    // anything else means the bridge never answers.
    task automatic run_txn(input logic wr, input logic [4:0] a, input logic [1:0] be,
                           input logic [15:0] wd, input int ack_at, input logic [15:0] rd);
        bit acked;
        int n;
        acked = (ack_at >= 1) && (ack_at <= int'(T));
        n     = acked ? ack_at : int'(T);
        chk_b("idle_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
        @(negedge clk_clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 5'($urandom);
        req_be    = 2'($urandom);
        req_wdata = 16'($urandom);
        if (!acked) exp_to = (exp_to < 255) ? exp_to + 1 : 255;
        for (int k = 1; k <= n + 1; k++) begin
            chk_b("busy", busy, 1'b1);
            chk_b("ready_low", req_ready, 1'b0);
            chk_b("bus_read", bus_read, (k <= n) && !wr);
            chk_b("bus_write", bus_write, (k <= n) && wr);
            chk_b("rsp_valid", rsp_valid, k == n + 1);
            if (k <= n) begin
                chk_w("bus_address", 16'(bus_address), 16'(a));
                chk_w("bus_byte_enable", 16'(bus_byte_enable), 16'(be));
                chk_w("bus_write_data", bus_write_data, wd);
            end else begin
                chk_w("rsp_rdata", rsp_rdata, (acked && !wr) ? rd : 16'h0000);
                chk_b("rsp_error", rsp_error, !acked);
                chk_w("timeout_count", 16'(timeout_count), 16'(exp_to));
            end
            if (k == n + 1) begin
                bus_acknowledge = 1'($urandom);
                bus_read_data   = 16'($urandom);
            end else if (acked && k == ack_at) begin
                bus_acknowledge = 1'b1;
                bus_read_data   = rd;
            end else begin
                bus_acknowledge = 1'b0;
                bus_read_data   = 16'($urandom);
            end
            @(negedge clk_clk);
        end
        bus_acknowledge = 1'b0;
        chk_b("post_ready", req_ready, 1'b1);
        chk_b("post_busy", busy, 1'b0);
        chk_b("post_rsp_valid", rsp_valid, 1'b0);
        chk_b("post_strobe", bus_read | bus_write, 1'b0);
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(negedge clk_clk);
        chk_b("rst_ready", req_ready, 1'b0);
        chk_b("rst_rsp_valid", rsp_valid, 1'b0);
        chk_b("rst_rsp_error", rsp_error, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_bus_read", bus_read, 1'b0);
        chk_b("rst_bus_write", bus_write, 1'b0);
        chk_w("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk_w("rst_bus_address", 16'(bus_address), 16'h0000);
        chk_w("rst_bus_be", 16'(bus_byte_enable), 16'h0000);
        chk_w("rst_bus_wdata", bus_write_data, 16'h0000);
        chk_w("rst_timeout_count", 16'(timeout_count), 16'h0000);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        chk_b("rel_ready", req_ready, 1'b1);

        // Directed cases.
        run_txn(1'b0, 5'h05, 2'b11, 16'($urandom), 1, 16'hA5C3);
        run_txn(1'b1, 5'h1F, 2'b01, 16'h00FF, 4, 16'($urandom));
        run_txn(1'b0, 5'h0A, 2'b11, 16'($urandom), 0, 16'($urandom));
        run_txn(1'b0, 5'h11, 2'b10, 16'($urandom), int'(T), 16'h1234);
        run_txn(1'b1, 5'h03, 2'b00, 16'hBEEF, 2, 16'($urandom));

        // Acknowledge while idle must not produce a response.
        for (int c = 0; c < 3; c++) begin
            bus_acknowledge = 1'b1;
            bus_read_data   = 16'($urandom);
            @(negedge clk_clk);
            chk_b("stale_rsp_valid", rsp_valid, 1'b0);
            chk_b("stale_busy", busy, 1'b0);
            chk_b("stale_strobe", bus_read | bus_write, 1'b0);
        end
        bus_acknowledge = 1'b0;

        // Back-to-back reads with valid and acknowledge held high.
        req_write = 1'b0;
        req_be    = 2'b11;
        for (int c = 0; c <= 8; c++) begin
            chk_b("b2b_ready", req_ready, (c % 3) == 0);
            chk_b("b2b_strobe", bus_read, (c % 3) == 1);
            chk_b("b2b_rsp_valid", rsp_valid, (c % 3) == 2);
            if ((c % 3) == 2) chk_w("b2b_rdata", rsp_rdata, rdq[c-1]);
            rdq[c]          = 16'($urandom);
            req_valid       = (c < 8);
            req_addr        = 5'($urandom);
            bus_acknowledge = 1'b1;
            bus_read_data   = rdq[c];
            @(negedge clk_clk);
        end
        bus_acknowledge = 1'b0;
        chk_b("b2b_end_busy", busy, 1'b0);
        chk_b("b2b_end_rsp", rsp_valid, 1'b0);

        // Randomized transactions, including some timeouts.
        for (int i = 0; i < 40; i++) begin
            int ak;
            ak = int'($urandom_range(0, T + 2));
            run_txn(1'($urandom), 5'($urandom), 2'($urandom), 16'($urandom), ak, 16'($urandom));
        end

        // Reset in the middle of an ACCESS.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'h07;
        @(negedge clk_clk);
        req_valid = 1'b0;
        @(negedge clk_clk);
        chk_b("mid_pre_strobe", bus_read, 1'b1);
        reset_reset = 1'b1;
        exp_to      = 0;
        #1;
        chk_b("mid_rst_read", bus_read, 1'b0);
        chk_b("mid_rst_write", bus_write, 1'b0);
        chk_b("mid_rst_busy", busy, 1'b0);
        chk_b("mid_rst_ready", req_ready, 1'b0);
        @(negedge clk_clk);
        chk_b("mid_rst_rsp", rsp_valid, 1'b0);
        reset_reset = 1'b0;
        repeat (3) begin
            @(negedge clk_clk);
            chk_b("mid_after_rsp", rsp_valid, 1'b0);
            chk_b("mid_after_ready", req_ready, 1'b1);
            chk_b("mid_after_strobe", bus_read | bus_write, 1'b0);
        end
        chk_w("mid_after_toc", 16'(timeout_count), 16'h0000);
        run_txn(1'b0, 5'h09, 2'b11, 16'($urandom), 3, 16'($urandom));

        // Saturation of the timeout counter.
        for (int i = 0; i < 300; i++) begin
            run_txn(1'($urandom), 5'($urandom), 2'($urandom), 16'($urandom), 0, 16'($urandom));
        end
        chk_w("toc_saturated", 16'(timeout_count), 16'h00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
